// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the receiver state encoding.
// Also used by the baud tick generator and the transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous level input, preset to 1 (idle line level).
module uart_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on a 16x oversampling tick: start validation, mid-bit sampling,
// stop check, and a one-entry holding register with a valid/ready handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    uart_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(rx),
        .sync_out(rx_s)
    );

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            // Half a bit in: a line that has returned high was only a glitch.
            START: begin
                if (baud_tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        if (!rx_s) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            // A consumer accepting on this very cycle frees the register for the new byte.
            STOP: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_d  = shift_q;
                                rx_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (baud_tick && rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that consumes the 16x-oversampling baud tick from the baud tick generator.
- Synchronises the asynchronous rx pin and detects and validates the start bit.
- Samples each data bit at mid-bit, LSB first, then checks the stop bit.
- Holds the received byte in a one-entry output register with a valid/ready handshake toward the core-side UART peripheral logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame; no parity; one stop bit.
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and >= 4.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- baud_tick  input  1  single-cycle enable pulse at OVERSAMPLE x baud rate.
- rx  input  1  raw serial line, asynchronous to clk, idle high.
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available in the holding register.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while rx_valid still 1.

Behaviour:
- Reset: async, active-low. Clock: clk.
  - State goes to IDLE.
  - tick_cnt, bit_cnt and the shift register clear to 0.
  - Synchroniser flops preset to 1.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame; no output pulses.
- Synchroniser: rx passes through 2 flops to give rx_s (2-cycle latency). Only rx_s is used internally.
- All FSM and counter activity advances only on cycles with baud_tick=1. Exception: the IDLE start check is level-based every clk.
- tick_cnt width is clog2(OVERSAMPLE). bit_cnt width is clog2(DATA_BITS+1).
- IDLE:
  - rx_s=0 -> START, tick_cnt=0.
- START:
  - On a tick with tick_cnt==OVERSAMPLE/2-1 (the 8th tick), sample rx_s:
    - 0: go to DATA, tick_cnt=0, bit_cnt=0.
    - 1: false start (glitch), return to IDLE.
  - Otherwise tick_cnt++.
- DATA:
  - On a tick with tick_cnt==OVERSAMPLE-1: shift rx_s into the MSB of the shift register (right shift, so the first bit ends at bit 0), then bit_cnt++, tick_cnt=0.
  - When bit_cnt reaches DATA_BITS-1 on this event -> STOP.
  - Otherwise tick_cnt++.
- STOP:
  - On a tick with tick_cnt==OVERSAMPLE-1, sample rx_s:
    - 1 and rx_valid=0 (or rx_valid & rx_ready this cycle): load rx_data, set rx_valid next cycle, go to IDLE.
    - 1 and rx_valid=1 with no handshake this cycle: pulse overrun for 1 cycle, discard the new byte, keep the old rx_data, go to IDLE.
    - 0: pulse frame_err for 1 cycle, discard the byte, go to BREAK.
  - Otherwise tick_cnt++.
- BREAK:
  - Wait for rx_s=1, then go to IDLE. Prevents a held-low line from producing repeated frames.
- Handshake:
  - rx_valid clears the cycle after a clk edge with rx_valid & rx_ready.
  - Simultaneous accept and new-byte load: the load wins, rx_valid stays 1, rx_data updates, no overrun.
  - rx_data holds its value while rx_valid=1 unless replaced by that simultaneous load.
- Latency: rx_valid rises on the clk edge following the stop-bit sampling tick.
- Centre sampling is nominal. The tick counter restarts at start detect, so cumulative drift is bounded per frame.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: IDLE, START, DATA, STOP, BREAK (3 bits);
  - OVERSAMPLE default;
  - DATA_BITS default.
- The baud tick generator and the future uart_tx use the same package.
- One sub-module, uart_sync: 2-flop synchroniser with async active-low reset, preset to 1. It is reused by other async inputs.

Test Plan:
- Bench drives baud_tick every 4 clk and rx at 1 bit per 64 clk.
- Nominal byte: frame for 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) -> one rx_valid with rx_data=0xA5; frame_err=0; overrun=0. Consumer rx_ready=1 clears rx_valid next cycle.
- False start: rx low for 12 clk (3 ticks) then high -> FSM returns to IDLE; no rx_valid and no error pulses.
- Framing error: byte 0x3C with stop bit driven 0 -> frame_err pulses exactly 1 cycle; rx_valid stays 0. FSM stays in BREAK until rx returns high, and a following 0x55 frame is then received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun pulses once at the 0x22 stop sample. After rx_ready=1, rx_valid clears.
- Back-to-back with simultaneous accept: rx_ready asserted exactly on the cycle 0x22 loads after 0x11 -> rx_data=0x22, rx_valid=1, overrun=0.
- Reset mid-frame: assert reset during data bit 4 of 0xFF -> all outputs 0 immediately. After release, the next 0x81 frame is received correctly.
